// File: rtl/video_pkg.sv
// Shared widths, palette field positions and pixel-phase encoding for the
// video pixel pipeline.
package video_pkg;

  localparam int PIX_W      = 4;
  localparam int BYTE_W     = 8;
  localparam int PIPE_DEPTH = 2;

  // Palette entry layout: {blue[7:6], green[5:3], red[2:0]}
  localparam int R_LSB = 0;
  localparam int R_MSB = 2;
  localparam int G_LSB = 3;
  localparam int G_MSB = 5;
  localparam int B_LSB = 6;
  localparam int B_MSB = 7;

  typedef enum logic {
    PH_LOAD = 1'b0,
    PH_LOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/video_delay.sv
// pix_ce-enabled shift register, reset to zero, used to align raster timing
// with the palette read latency.
module video_delay
  import video_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (ce) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/video_pixel_pipe.sv
// Byte-fed 4bpp pixel pipeline: splits bytes into two palette lookups against
// an external registered palette RAM and drives aligned RGB and timing.
module video_pixel_pipe
  import video_pkg::*;
#(
  parameter logic [PIX_W-1:0] UNDERRUN_INDEX = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              blank_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  // byte_ready/byte_valid: a byte transfers on a clk edge where both are 1.
  // byte_ready never depends on byte_valid; byte_valid is ignored when
  // byte_ready=0, and ready with valid=0 is an underrun, not a stall.
  output logic              byte_ready,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [PIX_W-1:0]  pal_addr,
  output logic              pal_en,
  input  logic [BYTE_W-1:0] pal_data,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              underrun,
  output logic [7:0]        underrun_cnt,
  input  logic              underrun_clr,
  output logic              dbg_phase
);

  phase_e            phase_q, phase_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              underrun_evt;

  assign byte_ready   = pix_ce & (phase_q == PH_LOAD) & ~blank_in;
  assign underrun_evt = byte_ready & ~byte_valid;
  assign pal_en       = pix_ce;
  assign pal_addr     = (phase_q == PH_LOW) ? shift_q[BYTE_W-1:PIX_W] : shift_q[PIX_W-1:0];
  assign dbg_phase    = phase_q;

  always_comb begin
    phase_d = phase_q;
    shift_d = shift_q;
    if (pix_ce) begin
      // Blanking wins over a pending low nibble so each line starts fresh.
      if (blank_in) begin
        phase_d = PH_LOAD;
        shift_d = '0;
      end else if (phase_q == PH_LOAD) begin
        shift_d = byte_valid ? byte_data : {UNDERRUN_INDEX, UNDERRUN_INDEX};
        phase_d = PH_LOW;
      end else begin
        phase_d = PH_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_LOAD;
      shift_q <= '0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
    end
  end

  // Timing is delayed to line up with pal_data, then registered with colour.
  logic [2:0] tim_dly;
  logic       dly_blank;

  video_delay #(.W(3), .DEPTH(PIPE_DEPTH)) u_timing_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce),
    .d     ({blank_in, hsync_in, vsync_in}),
    .q     (tim_dly)
  );

  assign dly_blank = tim_dly[2];

  logic [2:0] red_q, red_d, green_q, green_d;
  logic [1:0] blue_q, blue_d;
  logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_ce) begin
      red_d   = dly_blank ? 3'd0 : pal_data[R_MSB:R_LSB];
      green_d = dly_blank ? 3'd0 : pal_data[G_MSB:G_LSB];
      blue_d  = dly_blank ? 2'd0 : pal_data[B_MSB:B_LSB];
      de_d    = ~dly_blank;
      hsync_d = tim_dly[1];
      vsync_d = tim_dly[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

  logic       underrun_q, underrun_d;
  logic [7:0] cnt_q, cnt_d;

  // A clear coinciding with an event leaves exactly that one event counted.
  always_comb begin
    underrun_d = underrun_q;
    cnt_d      = cnt_q;
    if (underrun_clr) begin
      underrun_d = underrun_evt;
      cnt_d      = underrun_evt ? 8'd1 : 8'd0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_video_pixel_pipe.sv
// Directed bench for video_pixel_pipe with a behavioural registered palette
// RAM holding palette[i] = i*16+i.
module tb_video_pixel_pipe;

  logic       clk = 1'b0;
  logic       reset, pix_ce, blank_in, hsync_in, vsync_in;
  logic       byte_ready, byte_valid;
  logic [7:0] byte_data;
  logic [3:0] pal_addr;
  logic       pal_en;
  logic [7:0] pal_data = 8'h00;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       de, hsync, vsync, underrun, underrun_clr, dbg_phase;
  logic [7:0] underrun_cnt;
  logic [7:0] col;
  logic [7:0] pal_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  assign col = {blue, green, red};

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) pal_mem[i] = 8'(i * 16 + i);

  always @(posedge clk) if (pal_en) pal_data <= pal_mem[pal_addr];

  video_pixel_pipe #(.UNDERRUN_INDEX(4'h7)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_ce       (pix_ce),
    .blank_in     (blank_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .byte_ready   (byte_ready),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .pal_addr     (pal_addr),
    .pal_en       (pal_en),
    .pal_data     (pal_data),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .underrun_clr (underrun_clr),
    .dbg_phase    (dbg_phase)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pix_ce = 1'b1; blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h00; underrun_clr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_ce = 1'b0; blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    byte_valid = 1'b1; byte_data = 8'hFF; underrun_clr = 1'b0;
    step(); step();
    n_tests++;
    if ({col, de, hsync, vsync, underrun, underrun_cnt, dbg_phase} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got col=%h de=%b hs=%b vs=%b ur=%b cnt=%h ph=%b exp all 0",
               col, de, hsync, vsync, underrun, underrun_cnt, dbg_phase);
    end
    reset = 1'b0; pix_ce = 1'b1; blank_in = 1'b1; #1;
    n_tests++;
    if ({byte_ready, pal_en} !== 2'b01) begin
      n_fail++; $display("FAIL ready_in_blank got ready=%b en=%b exp ready=0 en=1", byte_ready, pal_en);
    end
    step();
    blank_in = 1'b0; pix_ce = 1'b0; #1;
    n_tests++;
    if ({byte_ready, pal_en} !== 2'b00) begin
      n_fail++; $display("FAIL ready_no_ce got ready=%b en=%b exp 0 0", byte_ready, pal_en);
    end
    pix_ce = 1'b1; #1;
    n_tests++;
    if (byte_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_ready got %b exp 1", byte_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_c [6];
    exp_c = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      byte_data = (e < 3) ? 8'h12 : 8'h34;
      blank_in  = (e >= 5);
      step();
      n_tests++;
      if (col !== exp_c[e-1] || de !== 1'b1) begin
        n_fail++; $display("FAIL basic_pixel e%0d got col=%h de=%b exp col=%h de=1", e, col, de, exp_c[e-1]);
      end
      if (e == 1) begin
        n_tests++;
        if (dbg_phase !== 1'b1 || pal_addr !== 4'h1) begin
          n_fail++; $display("FAIL basic_phase got ph=%b addr=%h exp ph=1 addr=1", dbg_phase, pal_addr);
        end
      end
    end
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL basic_no_underrun got %b exp 0", underrun);
    end
  endtask

  task automatic test_slow_ce();
    int k = 0;
    do_reset();
    byte_data = 8'hA5;
    for (int c = 0; c < 15; c++) begin
      pix_ce = ((c % 3) == 0);
      #1;
      if (!pix_ce) begin
        n_tests++;
        if (byte_ready !== 1'b0) begin
          n_fail++; $display("FAIL slow_ready c%0d got %b exp 0", c, byte_ready);
        end
      end
      step();
      if (pix_ce) k++;
      n_tests++;
      case (k)
        1: if (pal_addr !== 4'hA || col !== 8'h00) begin
             n_fail++; $display("FAIL slow_k1 c%0d got addr=%h col=%h exp addr=a col=00", c, pal_addr, col);
           end
        2: if (pal_addr !== 4'h5 || col !== 8'h00) begin
             n_fail++; $display("FAIL slow_k2 c%0d got addr=%h col=%h exp addr=5 col=00", c, pal_addr, col);
           end
        3: if (col !== 8'hAA) begin
             n_fail++; $display("FAIL slow_k3 c%0d got col=%h exp aa", c, col);
           end
        4: if (col !== 8'h55) begin
             n_fail++; $display("FAIL slow_k4 c%0d got col=%h exp 55", c, col);
           end
        default: if (col !== 8'hAA) begin
             n_fail++; $display("FAIL slow_k5 c%0d got col=%h exp aa", c, col);
           end
      endcase
    end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      byte_valid = (e != 1);
      blank_in   = (e >= 3);
      step();
      if (e == 1) begin
        n_tests++;
        if (underrun !== 1'b1 || underrun_cnt !== 8'd1) begin
          n_fail++; $display("FAIL underrun_flag got ur=%b cnt=%0d exp 1 1", underrun, underrun_cnt);
        end
      end
      if (e >= 3) begin
        n_tests++;
        if (col !== 8'h77 || de !== 1'b1) begin
          n_fail++; $display("FAIL underrun_pixel e%0d got col=%h de=%b exp 77 1", e, col, de);
        end
      end
    end
    blank_in = 1'b0; byte_valid = 1'b0; pix_ce = 1'b0;
    step(); step();
    n_tests++;
    if (underrun_cnt !== 8'd1) begin
      n_fail++; $display("FAIL underrun_no_ce got cnt=%0d exp 1", underrun_cnt);
    end
    byte_valid = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    byte_valid = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (i == 400) begin
        n_tests++;
        if (underrun_cnt !== 8'd200) begin
          n_fail++; $display("FAIL sat_mid got cnt=%0d exp 200", underrun_cnt);
        end
      end
    end
    n_tests++;
    if (underrun_cnt !== 8'hFF || underrun !== 1'b1) begin
      n_fail++; $display("FAIL sat_full got cnt=%h ur=%b exp ff 1", underrun_cnt, underrun);
    end
    underrun_clr = 1'b1; step();
    n_tests++;
    if (underrun_cnt !== 8'd1 || underrun !== 1'b1) begin
      n_fail++; $display("FAIL clr_with_event got cnt=%0d ur=%b exp 1 1", underrun_cnt, underrun);
    end
    step();
    n_tests++;
    if (underrun_cnt !== 8'd0 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone got cnt=%0d ur=%b exp 0 0", underrun_cnt, underrun);
    end
    underrun_clr = 1'b0; step();
    pix_ce = 1'b0; underrun_clr = 1'b1; step();
    n_tests++;
    if (underrun_cnt !== 8'd0 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_no_ce got cnt=%0d ur=%b exp 0 0", underrun_cnt, underrun);
    end
    underrun_clr = 1'b0; byte_valid = 1'b1;
  endtask

  task automatic test_blank();
    logic [7:0] exp_c;
    logic       exp_hs, exp_de;
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      byte_data = (e < 8) ? 8'h12 : 8'h34;
      blank_in  = (e >= 4 && e <= 7);
      hsync_in  = blank_in;
      vsync_in  = (e == 5);
      #1;
      if (e == 5 || e == 8) begin
        n_tests++;
        if (byte_ready !== (e == 8)) begin
          n_fail++; $display("FAIL blank_ready e%0d got %b exp %b", e, byte_ready, (e == 8));
        end
      end
      step();
      exp_hs = (e >= 6 && e <= 9);
      exp_de = !exp_hs;
      case (e)
        3, 5:    exp_c = 8'h11;
        4:       exp_c = 8'h22;
        10:      exp_c = 8'h33;
        11:      exp_c = 8'h44;
        default: exp_c = 8'h00;
      endcase
      n_tests++;
      if (hsync !== exp_hs || de !== exp_de || vsync !== (e == 7)) begin
        n_fail++; $display("FAIL blank_timing e%0d got hs=%b de=%b vs=%b exp hs=%b de=%b vs=%b",
                           e, hsync, de, vsync, exp_hs, exp_de, (e == 7));
      end
      if (e >= 3) begin
        n_tests++;
        if (col !== exp_c) begin
          n_fail++; $display("FAIL blank_pixel e%0d got col=%h exp %h", e, col, exp_c);
        end
      end
    end
    blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_c [4];
    exp_c = '{8'h00, 8'h00, 8'h55, 8'h66};
    do_reset();
    byte_data = 8'h12; hsync_in = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      byte_valid = (e != 1);
      step();
    end
    n_tests++;
    if (hsync !== 1'b1 || underrun_cnt !== 8'd1 || col === 8'h00) begin
      n_fail++; $display("FAIL mid_prefill got hs=%b cnt=%0d col=%h exp hs=1 cnt=1 col!=00", hsync, underrun_cnt, col);
    end
    reset = 1'b1; underrun_clr = 1'b1; step();
    n_tests++;
    if ({col, de, hsync, vsync, underrun, underrun_cnt, dbg_phase} !== 21'd0) begin
      n_fail++; $display("FAIL mid_reset got col=%h de=%b hs=%b vs=%b ur=%b cnt=%h ph=%b exp all 0",
                         col, de, hsync, vsync, underrun, underrun_cnt, dbg_phase);
    end
    step();
    reset = 1'b0; underrun_clr = 1'b0; hsync_in = 1'b0; byte_data = 8'h56;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_tests++;
      if (col !== exp_c[e-1] || hsync !== 1'b0) begin
        n_fail++; $display("FAIL mid_after e%0d got col=%h hs=%b exp col=%h hs=0", e, col, hsync, exp_c[e-1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_slow_ce();
    test_underrun();
    test_saturate();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pixel_pipe.md
VIDEO_PIXEL_PIPE -- requirements
Module: video_pixel_pipe

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter UNDERRUN_INDEX, default 4'h0: the palette index substituted for both pixels of a byte that is missing.
REQ-003 clk  in  1  system clock; all logic updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pix_ce  in  1  pixel clock enable; all pipeline registers advance only when it is 1.
REQ-006 blank_in, hsync_in, vsync_in  in  1 each  raster timing, sampled on pix_ce edges.
REQ-007 byte_ready  out  1  combinational request for a video byte in this cycle.
REQ-008 byte_valid  in  1  upstream byte is present; this is meaningful only when byte_ready=1.
REQ-009 byte_data  in  8  two 4-bit pixels; [7:4] is displayed first.
REQ-010 pal_addr  out  4  palette read address (combinational).
REQ-011 pal_en  out  1  palette read enable; it equals pix_ce.
REQ-012 pal_data  in  8  registered palette output, valid on the clk edge after pal_en=1; it holds its value otherwise.
REQ-013 red  out  3; green  out  3; blue  out  2  registered colour outputs.
REQ-014 de, hsync, vsync  out  1 each  registered timing outputs, aligned to the colour outputs.
REQ-015 underrun  out  1  sticky flag that a requested byte was missing.
REQ-016 underrun_cnt  out  8  count of underruns, saturating at 8'hFF.
REQ-017 underrun_clr  in  1  clears underrun and underrun_cnt.

Function
REQ-018 phase (1 bit) SHALL select the pixel: 0 means load a new byte, 1 means the low nibble is still pending.
REQ-019 byte_ready SHALL equal pix_ce & ~phase & ~blank_in.
REQ-020 On a pix_ce edge with blank_in=1, the block SHALL set phase<=0 and shift_reg<=8'h00.
REQ-021 On a pix_ce edge with byte_ready=1 and byte_valid=1, the block SHALL set shift_reg<=byte_data and phase<=1.
REQ-022 On a pix_ce edge with byte_ready=1 and byte_valid=0, the block SHALL set shift_reg<={UNDERRUN_INDEX,UNDERRUN_INDEX}, phase<=1, and register an underrun event.
REQ-023 On a pix_ce edge with phase=1 and blank_in=0, the block SHALL set phase<=0.
REQ-024 pal_addr SHALL be shift_reg[7:4] when phase=1 and shift_reg[3:0] when phase=0.
REQ-025 Output stage: on a pix_ce edge, red<=pal_data[2:0], green<=pal_data[5:3], blue<=pal_data[7:6], and each is forced to 0 when the delayed blank is 1.
REQ-026 Latency: a byte loaded at pix_ce edge n SHALL show its high nibble's colour after edge n+2 and its low nibble's colour after edge n+3.
REQ-027 blank_in, hsync_in and vsync_in sampled at edge n SHALL appear after edge n+2, with de = ~blank delayed.
REQ-028 With pix_ce=0, no register changes except the underrun logic on underrun_clr.
REQ-029 Underrun event: underrun<=1 and underrun_cnt increments, holding at 8'hFF.
REQ-030 underrun_clr=1 SHALL clear both underrun and underrun_cnt; if an event occurs in the same cycle, the result is underrun=1 and underrun_cnt=1.
REQ-031 blank_in rising while phase=1 SHALL discard the low nibble; the next active line starts at phase 0.

Reset
REQ-032 Reset SHALL force phase=0, shift_reg=0, all delay stages=0, red/green/blue=0, de=0, hsync=0, vsync=0, underrun=0, and underrun_cnt=0.
REQ-033 Reset SHALL take priority over pix_ce and underrun_clr.
REQ-034 Reset asserted mid-line SHALL discard all pipeline contents.
REQ-035 After reset, the first byte_ready SHALL occur on the first pix_ce with blank_in=0.

Structure
REQ-036 Shared package video_pkg SHALL hold the palette field bit positions (R [2:0], G [5:3], B [7:6]), PIPE_DEPTH=2, and the pixel/byte widths.
REQ-037 Sub-module video_delay SHALL be a PIPE_DEPTH-stage, pix_ce-enabled, reset-to-0 shift register used for blank, hsync and vsync.
REQ-038 The palette RAM SHALL be external; the block SHALL contain no storage beyond its registers.

Verification
REQ-039 Reset, then blank_in=0 and pix_ce every cycle with bytes 8'h12, 8'h34 and palette[i]=i*16+i -> outputs 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles starting 2 cycles after the first load.
REQ-040 pix_ce every 3rd cycle with byte 8'hA5 -> pal_addr A then 5, outputs change only after pix_ce edges, and the latency in pix_ce edges matches REQ-026.
REQ-041 Hold byte_valid=0 on one request with UNDERRUN_INDEX=4'h7 -> two pixels of palette[7], underrun=1, and underrun_cnt=1.
REQ-042 Force 300 underruns -> underrun_cnt=8'hFF; underrun_clr together with a new event -> underrun_cnt=1.
REQ-043 hsync_in and blank_in pulsed for 4 pix_ce -> hsync/de delayed exactly 2 pix_ce, RGB=0 while de=0, and the next line starts on the high nibble.
REQ-044 Assert reset mid-line -> all outputs 0 on the next edge and no stale pixels after reset is released.
